// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with counter timebase, valid/ready output stream and error pulses.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_HZ   = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV = CLOCK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e      state;
    logic        sync1;
    logic        rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        busy_q;
    logic        frame_error_q;
    logic        overrun_q;

    logic        cnt_zero;
    logic        stop_sample;
    logic        push;
    logic        can_accept;
    logic        falling;

    // Line idles high, so both synchronizer flops reset to 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
        end
    end

    // rx_s is 1 now and takes the 0 already in sync1 on this edge.
    assign falling     = rx_s && !sync1;
    assign cnt_zero    = (cnt == '0);
    assign stop_sample = (state == StStop) && cnt_zero;
    assign push        = stop_sample && rx_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= StIdle;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            if (!cnt_zero) begin
                cnt <= cnt - CW'(1);
            end
            case (state)
                StIdle: begin
                    if (falling) begin
                        cnt    <= HALF_LOAD;
                        state  <= StStart;
                        busy_q <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt_zero) begin
                        if (rx_s) begin
                            state  <= StIdle;
                            busy_q <= 1'b0;
                        end else begin
                            cnt     <= FULL_LOAD;
                            bit_idx <= '0;
                            state   <= StData;
                        end
                    end
                end
                StData: begin
                    if (cnt_zero) begin
                        shift   <= {rx_s, shift[7:1]};
                        cnt     <= FULL_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (cnt_zero) begin
                        if (rx_s) begin
                            overrun_q <= !can_accept;
                            state     <= StIdle;
                            busy_q    <= 1'b0;
                        end else begin
                            frame_error_q <= 1'b1;
                            state         <= StBreak;
                        end
                    end
                end
                StBreak: begin
                    // Held-low line: stay here so only one frame_error is reported.
                    if (rx_s) begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= StIdle;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_next;
    logic [AW:0] rd_next;
    logic        empty;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        valid_q;
    logic        valid_d;
    logic [7:0]  data_q;
    logic [7:0]  data_d;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = valid_q && ready;
    assign can_accept = !full || pop;
    assign wr_en      = push && can_accept;

    always_comb begin
        rd_next = pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
        wr_next = wr_en ? wr_ptr + (AW+1)'(1) : wr_ptr;
        valid_d = (wr_next != rd_next);
        // When the old contents are exhausted the new head is the byte being written.
        if (rd_next == wr_ptr) begin
            data_d = wr_en ? shift : data_q;
        end else begin
            data_d = mem[rd_next[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

    logic unused_empty;
    assign unused_empty = empty;
`else
    logic       full_q;
    logic [7:0] data_q;
    logic       pop;

    assign pop        = full_q && ready;
    assign can_accept = !full_q || pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else if (push && can_accept) begin
            full_q <= 1'b1;
            data_q <= shift;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    assign data  = data_q;
    assign valid = full_q;
`endif

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

    // Configuration sanity: bit period long enough, buffer depth a power of two.
    cfg_ok_a : assert property (@(posedge clock)
        (DIV >= 16) && (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default clock/baud; buffering section follows UART_RX_FIFO_EN.
module tb_uart_rx_fifo;

    localparam int DIV = 27000000 / 115200;

    logic       clock;
    logic       reset_n;
    logic       uart_rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int valid_cycles = 0;
    int fe_cnt = 0;
    int fe_cyc = 0;
    int ov_cnt = 0;
    int rx_first_cyc = -1;
    int rx_last_cyc = -1;
    logic [7:0] rx_q[$];

    uart_rx_fifo dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .uart_rx     (uart_rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (valid) valid_cycles = valid_cycles + 1;
        if (valid && ready) begin
            rx_q.push_back(data);
            if (rx_first_cyc < 0) rx_first_cyc = cyc;
            rx_last_cyc = cyc;
        end
        if (frame_error) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (overrun) ov_cnt = ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        valid_cycles = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        rx_first_cyc = -1;
        rx_last_cyc = -1;
        rx_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        uart_rx = b;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        fall_cyc = cyc;
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 8; i++) drive_bit(v[i], DIV);
        drive_bit(stop_bit, DIV);
        uart_rx = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        uart_rx = 1'b1;
        ready   = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);

        // Reset state
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // Single byte, consumer always ready
        ready = 1'b1;
        clear_log();
        send_frame(8'hA5, 1'b1);
        wait_cycles(10);
        check("single_count", 32'(rx_q.size()), 32'd1);
        check("single_data", 32'(rx_q[0]), 32'hA5);
        check("single_latency", 32'(rx_first_cyc - fall_cyc), 32'd2225);
        check("single_valid_cycles", 32'(valid_cycles), 32'd1);
        check("single_no_fe", 32'(fe_cnt), 32'd0);
        check("single_no_ov", 32'(ov_cnt), 32'd0);

        // Glitch: 50-cycle low pulse is rejected at the start-bit sample
        clear_log();
        fall_cyc = cyc;
        drive_bit(1'b0, 50);
        uart_rx = 1'b1;
        wait_cycles(68);
        check("glitch_busy_before_sample", 32'(busy), 32'd1);
        wait_cycles(1);
        check("glitch_busy_after_sample", 32'(busy), 32'd0);
        wait_cycles(3 * DIV);
        check("glitch_no_valid", 32'(valid_cycles), 32'd0);

        // Framing error with line held low for 20 bit times
        clear_log();
        fall_cyc = cyc;
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'h3C;
            drive_bit(v[i], DIV);
        end
        drive_bit(1'b0, 20 * DIV);
        drive_bit(1'b1, 2 * DIV);
        check("fe_count", 32'(fe_cnt), 32'd1);
        check("fe_timing", 32'(fe_cyc - fall_cyc), 32'd2225);
        check("fe_no_valid", 32'(valid_cycles), 32'd0);
        check("fe_busy_cleared", 32'(busy), 32'd0);
        send_frame(8'h55, 1'b1);
        wait_cycles(10);
        check("after_fe_count", 32'(rx_q.size()), 32'd1);
        check("after_fe_data", 32'(rx_q[0]), 32'h55);

`ifdef UART_RX_FIFO_EN
        // Nine back-to-back bytes into an 8-deep FIFO with no consumer
        ready = 1'b0;
        clear_log();
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
        wait_cycles(10);
        check("fifo_overrun_count", 32'(ov_cnt), 32'd1);
        check("fifo_valid_held", 32'(valid), 32'd1);
        check("fifo_head", 32'(data), 32'h00);
        ready = 1'b1;
        wait_cycles(20);
        ready = 1'b0;
        check("fifo_drain_count", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("fifo_drain_order", 32'(rx_q[i]), 32'(i));
        check("fifo_drain_rate", 32'(rx_last_cyc - rx_first_cyc), 32'd7);
        check("fifo_empty_after", 32'(valid), 32'd0);
`else
        // Two bytes into the holding register with no consumer
        ready = 1'b0;
        clear_log();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(10);
        check("hold_overrun_count", 32'(ov_cnt), 32'd1);
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data_kept", 32'(data), 32'h11);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
        wait_cycles(2);
        check("hold_pop_count", 32'(rx_q.size()), 32'd1);
        check("hold_pop_data", 32'(rx_q[0]), 32'h11);
        check("hold_empty_after", 32'(valid), 32'd0);
`endif

        // Reset mid-frame with a byte already pending
        ready = 1'b0;
        clear_log();
        send_frame(8'h5A, 1'b1);
        wait_cycles(5);
        check("pre_reset_valid", 32'(valid), 32'd1);
        check("pre_reset_data", 32'(data), 32'h5A);
        drive_bit(1'b0, DIV);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, DIV);
        drive_bit(1'b1, DIV / 2);
        check("mid_frame_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_valid", 32'(valid), 32'd0);
        check("mid_reset_data", 32'(data), 32'h00);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_fe", 32'(frame_error), 32'd0);
        check("mid_reset_ov", 32'(overrun), 32'd0);
        wait_cycles(3);
        reset_n = 1'b1;
        drive_bit(1'b1, 5 * DIV);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_valid", 32'(valid), 32'd0);
        ready = 1'b1;
        clear_log();
        send_frame(8'h81, 1'b1);
        wait_cycles(10);
        check("post_reset_count", 32'(rx_q.size()), 32'd1);
        check("post_reset_data", 32'(rx_q[0]), 32'h81);
        check("post_reset_no_fe", 32'(fe_cnt), 32'd0);
        check("post_reset_no_ov", 32'(ov_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
